// File: rtl/calc_arb_if.sv
// Handshake bundle between the calc front-end requesters, the result consumer and calc_arb.
// Signal suffixes are from the arbiter's point of view.
interface calc_arb_if;
    logic       req0_i;
    logic [3:0] a0_i;
    logic [3:0] b0_i;
    logic       gnt0_o;
    logic       req1_i;
    logic [3:0] a1_i;
    logic [3:0] b1_i;
    logic       gnt1_o;
    logic       resValid_o;
    logic       resReady_i;
    logic       resId_o;
    logic [5:0] resData_o;
    logic       drop_o;

    modport slave (
        input  req0_i, a0_i, b0_i, req1_i, a1_i, b1_i, resReady_i,
        output gnt0_o, gnt1_o, resValid_o, resId_o, resData_o, drop_o
    );

    modport master (
        output req0_i, a0_i, b0_i, req1_i, a1_i, b1_i, resReady_i,
        input  gnt0_o, gnt1_o, resValid_o, resId_o, resData_o, drop_o
    );
endinterface

// File: rtl/calc_arb.sv
// Two-requester arbiter/sequencer around a shared 4-bit ripple adder with a timed result hold.
// Optional macro CALC_ARB_FIXED_PRIO_EN: requester 0 always wins ties instead of round-robin.
module add (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [4:0] sum_o
);
    logic [4:0] carry;
    logic [3:0] bitSum;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign bitSum[i]  = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign sum_o = {carry[4], bitSum};
endmodule

module calc_arb #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    calc_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

    state_t     state_q;
    logic [3:0] opA_q;
    logic [3:0] opB_q;
    logic       resId_q;
    logic [5:0] resData_q;
    logic       resValid_q;
    logic       drop_q;
    logic [7:0] waitCnt_q;
    logic       prio_q;

    logic       anyReq;
    logic       winner_d;
    logic [4:0] subData;
    logic       timeoutHit;
    logic [8:0] waitCnt_d;

    add u_add (
        .a_i   (opA_q),
        .b_i   (opB_q),
        .sum_o (subData)
    );

    // prio_q stays 0 in the fixed-priority build, so the same tie-break serves both builds.
    assign anyReq   = bus.req0_i | bus.req1_i;
    assign winner_d = (bus.req0_i & bus.req1_i) ? prio_q : ~bus.req0_i;

    assign bus.gnt0_o = (state_q == IDLE) & anyReq & ~winner_d;
    assign bus.gnt1_o = (state_q == IDLE) & anyReq &  winner_d;

    assign waitCnt_d  = {1'b0, waitCnt_q} + 9'd1;
    assign timeoutHit = (TIMEOUT_C != 9'd0) && (waitCnt_d == TIMEOUT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            resId_q    <= 1'b0;
            resData_q  <= '0;
            resValid_q <= 1'b0;
            drop_q     <= 1'b0;
            waitCnt_q  <= '0;
            prio_q     <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        opA_q   <= winner_d ? bus.a1_i : bus.a0_i;
                        opB_q   <= winner_d ? bus.b1_i : bus.b0_i;
                        resId_q <= winner_d;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    resData_q  <= {1'b0, subData};
                    resValid_q <= 1'b1;
                    waitCnt_q  <= '0;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    // Acceptance takes precedence over a timeout landing on the same edge.
                    if (bus.resReady_i || timeoutHit) begin
                        resValid_q <= 1'b0;
                        drop_q     <= ~bus.resReady_i;
                        state_q    <= IDLE;
`ifdef CALC_ARB_FIXED_PRIO_EN
                        prio_q     <= 1'b0;
`else
                        prio_q     <= ~resId_q;
`endif
                    end else if (TIMEOUT_C != 9'd0) begin
                        waitCnt_q <= waitCnt_d[7:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.resValid_o = resValid_q;
    assign bus.resId_o    = resId_q;
    assign bus.resData_o  = resData_q;
    assign bus.drop_o     = drop_q;
endmodule

// File: tb/tb_calc_arb.sv
// Directed self-checking bench for calc_arb built with TIMEOUT=4.
// Expected values are hand-computed constants for each step.
module tb_calc_arb;
    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    calc_arb_if bus ();

    calc_arb #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CALC_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic [3:0] a0, input logic [3:0] b0,
                                 input logic r1, input logic [3:0] a1, input logic [3:0] b1,
                                 input logic rdy);
        bus.req0_i     = r0;
        bus.a0_i       = a0;
        bus.b0_i       = b0;
        bus.req1_i     = r1;
        bus.a1_i       = a1;
        bus.b1_i       = b1;
        bus.resReady_i = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
            $error("[TB] %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        logic expGnt1;
        checkCount = 0;
        errorCount = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
        #3;
        checkOutput("rst_gnt0",  {7'd0, bus.gnt0_o},     8'd0);
        checkOutput("rst_gnt1",  {7'd0, bus.gnt1_o},     8'd0);
        checkOutput("rst_valid", {7'd0, bus.resValid_o}, 8'd0);
        checkOutput("rst_id",    {7'd0, bus.resId_o},    8'd0);
        checkOutput("rst_data",  {2'd0, bus.resData_o},  8'd0);
        checkOutput("rst_drop",  {7'd0, bus.drop_o},     8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] single request 3+4 on requester 0");
        applyStimulus(1'b1, 4'd3, 4'd4, 1'b0, 4'd0, 4'd0, 1'b0);
        #1;
        checkOutput("a_gnt0", {7'd0, bus.gnt0_o}, 8'd1);
        checkOutput("a_gnt1", {7'd0, bus.gnt1_o}, 8'd0);
        tick();
        checkOutput("a_calc_gnt0", {7'd0, bus.gnt0_o}, 8'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("a_calc_valid", {7'd0, bus.resValid_o}, 8'd0);
        tick();
        checkOutput("a_valid", {7'd0, bus.resValid_o}, 8'd1);
        checkOutput("a_data",  {2'd0, bus.resData_o},  8'd7);
        checkOutput("a_id",    {7'd0, bus.resId_o},    8'd0);
        tick();
        checkOutput("a_retired", {7'd0, bus.resValid_o}, 8'd0);
        checkOutput("a_nodrop",  {7'd0, bus.drop_o},     8'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);

        $display("[TB] 15+15 on requester 1");
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 4'd15, 1'b0);
        #1;
        checkOutput("b_gnt1", {7'd0, bus.gnt1_o}, 8'd1);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        checkOutput("b_data",  {2'd0, bus.resData_o},   8'd30);
        checkOutput("b_id",    {7'd0, bus.resId_o},     8'd1);
        checkOutput("b_bit5",  {7'd0, bus.resData_o[5]}, 8'd0);
        bus.resReady_i = 1'b1;
        tick();
        checkOutput("b_retired", {7'd0, bus.resValid_o}, 8'd0);

        $display("[TB] both requesting with ready held high");
        applyStimulus(1'b1, 4'd1, 4'd2, 1'b1, 4'd8, 4'd9, 1'b1);
        for (int k = 0; k < 4; k++) begin
            expGnt1 = FIXED ? 1'b0 : k[0];
            #1;
            checkOutput("rr_gnt0", {7'd0, bus.gnt0_o}, {7'd0, ~expGnt1});
            checkOutput("rr_gnt1", {7'd0, bus.gnt1_o}, {7'd0, expGnt1});
            tick();
            checkOutput("rr_calc_gnt", {6'd0, bus.gnt1_o, bus.gnt0_o}, 8'd0);
            tick();
            checkOutput("rr_data", {2'd0, bus.resData_o}, expGnt1 ? 8'd17 : 8'd3);
            checkOutput("rr_id",   {7'd0, bus.resId_o},   {7'd0, expGnt1});
            tick();
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);

        $display("[TB] request withdrawn before the grant edge");
        bus.req0_i = 1'b1;
        #1;
        checkOutput("w_gnt0", {7'd0, bus.gnt0_o}, 8'd1);
        bus.req0_i = 1'b0;
        tick();
        tick();
        checkOutput("w_valid", {7'd0, bus.resValid_o}, 8'd0);
        checkOutput("w_gnt0_after", {7'd0, bus.gnt0_o}, 8'd0);

        $display("[TB] timeout drop with ready low");
        applyStimulus(1'b1, 4'd9, 4'd8, 1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        bus.req0_i = 1'b0;
        tick();
        checkOutput("t_data", {2'd0, bus.resData_o}, 8'd17);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t_hold_valid", {7'd0, bus.resValid_o}, 8'd1);
            checkOutput("t_hold_drop",  {7'd0, bus.drop_o},     8'd0);
        end
        tick();
        checkOutput("t_dropped_valid", {7'd0, bus.resValid_o}, 8'd0);
        checkOutput("t_drop_pulse",    {7'd0, bus.drop_o},     8'd1);
        applyStimulus(1'b1, 4'd1, 4'd1, 1'b1, 4'd5, 4'd6, 1'b0);
        #1;
        checkOutput("t_next_gnt1", {7'd0, bus.gnt1_o}, FIXED ? 8'd0 : 8'd1);
        tick();
        checkOutput("t_drop_end", {7'd0, bus.drop_o}, 8'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        checkOutput("t2_data", {2'd0, bus.resData_o}, FIXED ? 8'd2 : 8'd11);

        $display("[TB] ready on the exact timeout edge");
        tick();
        tick();
        tick();
        checkOutput("e_still_valid", {7'd0, bus.resValid_o}, 8'd1);
        bus.resReady_i = 1'b1;
        tick();
        checkOutput("e_valid", {7'd0, bus.resValid_o}, 8'd0);
        checkOutput("e_nodrop", {7'd0, bus.drop_o}, 8'd0);

        $display("[TB] reset during HOLD");
        applyStimulus(1'b1, 4'd6, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1);
        tick();
        bus.req0_i = 1'b0;
        tick();
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 4'd2, 1'b0);
        tick();
        bus.req1_i = 1'b0;
        tick();
        checkOutput("r_valid_before", {7'd0, bus.resValid_o}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("r_valid", {7'd0, bus.resValid_o}, 8'd0);
        checkOutput("r_data",  {2'd0, bus.resData_o},  8'd0);
        checkOutput("r_id",    {7'd0, bus.resId_o},    8'd0);
        checkOutput("r_drop",  {7'd0, bus.drop_o},     8'd0);
        tick();
        checkOutput("r_drop_later", {7'd0, bus.drop_o}, 8'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0);
        #1;
        checkOutput("r_prio_gnt0", {7'd0, bus.gnt0_o}, 8'd1);
        checkOutput("r_prio_gnt1", {7'd0, bus.gnt1_o}, 8'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
